// File: rtl/vending_pkg.sv
// Shared definitions for the vending_moore_change controller.
//   state_e    : controller state encoding, also driven on State_out
//   *_V        : coin values in nickel units
//   is_busy()  : true in the states that reject every incoming coin
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    REFUND = 3'd4
  } state_e;

  localparam logic [2:0] NICKEL_V  = 3'd1;
  localparam logic [2:0] DIME_V    = 3'd2;
  localparam logic [2:0] QUARTER_V = 3'd5;

  function automatic logic is_busy(input state_e s);
    return (s == VEND) || (s == CHANGE) || (s == REFUND);
  endfunction

endpackage

// File: rtl/vending_moore_change_coin_decoder.sv
// coin_decoder: combinational classifier for the coin-acceptor pulses.
//   nickel, dime, quarter : one-cycle coin pulses
//   valid                 : exactly one accepted coin is present
//   invalid               : some coin is present but it cannot be credited
//   value                 : coin value in nickels (0 unless valid)
// QUARTER_EN = 0 turns a lone quarter into an invalid coin.
module coin_decoder
  import vending_pkg::*;
#(
  parameter bit QUARTER_EN = 1'b1
) (
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  output logic       valid,
  output logic       invalid,
  output logic [2:0] value
);

  logic any_coin;
  logic one_coin;

  always_comb begin
    any_coin = nickel | dime | quarter;
    // Odd parity rules out two coins; the AND term rules out all three.
    one_coin = (nickel ^ dime ^ quarter) & ~(nickel & dime & quarter);
    valid    = one_coin & ~(quarter & ~QUARTER_EN);
    invalid  = any_coin & ~valid;
    value    = 3'd0;
    if (valid) begin
      if (nickel)    value = NICKEL_V;
      else if (dime) value = DIME_V;
      else           value = QUARTER_V;
    end
  end

endmodule

// File: rtl/vending_moore_change.sv
// vending_moore_change: Moore vending controller with binary credit counter.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   Nickel/Dime/Quarter : one-cycle coin pulses (1/2/5 nickels)
//   Cancel      : refund request, honoured only while accumulating credit
//   Vend        : one-cycle dispense strobe
//   Change      : one pulse per nickel returned (after a vend or on refund)
//   Coin_reject : one-cycle pulse, the cycle after a coin that was not taken
//   Credit      : current credit in nickels
//   State_out   : raw state encoding for debug LEDs
// All outputs come from flops; nothing combinational reaches a port.
module vending_moore_change
  import vending_pkg::*;
#(
  parameter int  PRICE      = 3,
  parameter bit  QUARTER_EN = 1'b1,
  localparam int CREDIT_W   = $clog2(PRICE + 5)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Nickel,
  input  logic                Dime,
  input  logic                Quarter,
  input  logic                Cancel,
  output logic                Vend,
  output logic                Change,
  output logic                Coin_reject,
  output logic [CREDIT_W-1:0] Credit,
  output logic [2:0]          State_out
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  logic       coin_valid;
  logic       coin_invalid;
  logic [2:0] coin_value;
  logic       coin_any;

  coin_decoder #(
    .QUARTER_EN (QUARTER_EN)
  ) u_coin_decoder (
    .nickel  (Nickel),
    .dime    (Dime),
    .quarter (Quarter),
    .valid   (coin_valid),
    .invalid (coin_invalid),
    .value   (coin_value)
  );

  assign coin_any = coin_valid | coin_invalid;

  state_e              state;
  state_e              state_n;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_n;
  logic [CREDIT_W-1:0] credit_sum;
  logic                reject_n;
  logic                coin_reject;
  logic                vend;
  logic                change;

  // Next-state and next-credit decode.
  always_comb begin
    state_n    = state;
    credit_n   = credit;
    reject_n   = 1'b0;
    // Largest reachable sum is (PRICE-1)+5, which CREDIT_W always holds.
    credit_sum = credit + CREDIT_W'(coin_value);

    case (state)
      IDLE, ACCUM: begin
        if (Cancel) begin
          // Cancel takes priority over a simultaneous coin, which is returned.
          reject_n = coin_any;
          if (state == ACCUM) state_n = REFUND;
        end else if (coin_valid) begin
          if (credit_sum >= PRICE_C) begin
            state_n  = VEND;
            credit_n = credit_sum - PRICE_C;
          end else begin
            state_n  = ACCUM;
            credit_n = credit_sum;
          end
        end else if (coin_invalid) begin
          reject_n = 1'b1;
        end
      end

      VEND: begin
        reject_n = coin_any;
        state_n  = (credit != '0) ? CHANGE : IDLE;
      end

      CHANGE, REFUND: begin
        reject_n = coin_any;
        // Guarding on <=1 also keeps the counter from wrapping below zero.
        if (credit <= ONE_C) begin
          credit_n = '0;
          state_n  = IDLE;
        end else begin
          credit_n = credit - ONE_C;
        end
      end

      default: begin
        state_n  = IDLE;
        credit_n = '0;
      end
    endcase
  end

  // State, credit and output registers. Vend/Change are registered from the
  // next state so they are high exactly while the state register holds
  // VEND / CHANGE / REFUND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
      vend        <= 1'b0;
      change      <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      coin_reject <= reject_n;
      vend        <= (state_n == VEND);
      change      <= (state_n == CHANGE) || (state_n == REFUND);
    end
  end

  assign Vend        = vend;
  assign Change      = change;
  assign Coin_reject = coin_reject;
  assign Credit      = credit;
  assign State_out   = state;

  // Credit can never exceed one coin short of the price plus a quarter.
  credit_bound_a : assert property (
    @(posedge clk) disable iff (reset) int'(credit) <= PRICE + 4
  );

  // Vend and Change are mutually exclusive; Change only while paying out.
  vend_change_excl_a : assert property (
    @(posedge clk) disable iff (reset) !(vend && change)
  );

  busy_outputs_a : assert property (
    @(posedge clk) disable iff (reset) (vend || change) -> is_busy(state)
  );

endmodule

// File: tb/tb_vending_moore_change.sv
// Scoreboard bench for vending_moore_change. Two instances: dut_a with
// PRICE=3/QUARTER_EN=1 and dut_b with PRICE=3/QUARTER_EN=0. Each stimulus
// step pushes the hand-computed output tuple expected after the sampling
// edge; a monitor per instance pops and compares on every falling edge.
// Tuple packing: {Vend, Change, Coin_reject, Credit[2:0], State_out[2:0]}.
module tb_vending_moore_change;

  logic clk = 1'b0;
  logic reset;
  logic na, da, qa, ca;
  logic nb, db, qb, cb;

  logic       vend_a, change_a, rej_a;
  logic [2:0] credit_a, state_a;
  logic       vend_b, change_b, rej_b;
  logic [2:0] credit_b, state_b;

  int nvec = 0;
  int nerr = 0;
  int vid_a = 0;
  int vid_b = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  always #5 clk = ~clk;

  vending_moore_change #(.PRICE(3), .QUARTER_EN(1'b1)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .Nickel      (na),
    .Dime        (da),
    .Quarter     (qa),
    .Cancel      (ca),
    .Vend        (vend_a),
    .Change      (change_a),
    .Coin_reject (rej_a),
    .Credit      (credit_a),
    .State_out   (state_a)
  );

  vending_moore_change #(.PRICE(3), .QUARTER_EN(1'b0)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .Nickel      (nb),
    .Dime        (db),
    .Quarter     (qb),
    .Cancel      (cb),
    .Vend        (vend_b),
    .Change      (change_b),
    .Coin_reject (rej_b),
    .Credit      (credit_b),
    .State_out   (state_b)
  );

  function automatic logic [8:0] ex(input bit v, input bit ch, input bit rj,
                                    input int cr, input int st);
    logic [2:0] c3;
    logic [2:0] s3;
    c3 = 3'(cr);
    s3 = 3'(st);
    return {v, ch, rj, c3, s3};
  endfunction

  task automatic check(input string name, input int id,
                       input logic [8:0] act, input logic [8:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s #%0d: got vend=%0b change=%0b rej=%0b credit=%0d state=%0d, want vend=%0b change=%0b rej=%0b credit=%0d state=%0d",
               name, id, act[8], act[7], act[6], act[5:3], act[2:0],
               exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
    end
  endtask

  // Monitors: compare whatever the scoreboard holds for this cycle.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      logic [8:0] e;
      e = q_a.pop_front();
      vid_a++;
      check("dut_a", vid_a, {vend_a, change_a, rej_a, credit_a, state_a}, e);
    end
  end

  always @(negedge clk) begin
    if (q_b.size() > 0) begin
      logic [8:0] e;
      e = q_b.pop_front();
      vid_b++;
      check("dut_b", vid_b, {vend_b, change_b, rej_b, credit_b, state_b}, e);
    end
  end

  task automatic step_a(input logic n, input logic d, input logic q,
                        input logic c, input logic [8:0] e);
    na = n; da = d; qa = q; ca = c;
    @(posedge clk);
    q_a.push_back(e);
    #1;
    na = 1'b0; da = 1'b0; qa = 1'b0; ca = 1'b0;
  endtask

  task automatic step_b(input logic n, input logic d, input logic q,
                        input logic c, input logic [8:0] e);
    nb = n; db = d; qb = q; cb = c;
    @(posedge clk);
    q_b.push_back(e);
    #1;
    nb = 1'b0; db = 1'b0; qb = 1'b0; cb = 1'b0;
  endtask

  localparam int S_IDLE = 0, S_ACCUM = 1, S_VEND = 2, S_CHANGE = 3, S_REFUND = 4;

  initial begin
    int waited;
    reset = 1'b1;
    na = 0; da = 0; qa = 0; ca = 0;
    nb = 0; db = 0; qb = 0; cb = 0;
    #2;
    check("reset_a", 0, {vend_a, change_a, rej_a, credit_a, state_a}, ex(0,0,0,0,S_IDLE));
    check("reset_b", 0, {vend_b, change_b, rej_b, credit_b, state_b}, ex(0,0,0,0,S_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // Nickel then Dime: exact price, no change.
    step_a(1,0,0,0, ex(0,0,0,1,S_ACCUM));
    step_a(0,1,0,0, ex(1,0,0,0,S_VEND));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Dime, Dime: one nickel change.
    step_a(0,1,0,0, ex(0,0,0,2,S_ACCUM));
    step_a(0,1,0,0, ex(1,0,0,1,S_VEND));
    step_a(0,0,0,0, ex(0,1,0,1,S_CHANGE));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Quarter from IDLE: two change nickels.
    step_a(0,0,1,0, ex(1,0,0,2,S_VEND));
    step_a(0,0,0,0, ex(0,1,0,2,S_CHANGE));
    step_a(0,0,0,0, ex(0,1,0,1,S_CHANGE));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Nickel then Cancel: one refund nickel. Then Cancel in IDLE: no effect.
    step_a(1,0,0,0, ex(0,0,0,1,S_ACCUM));
    step_a(0,0,0,1, ex(0,1,0,1,S_REFUND));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));
    step_a(0,0,0,1, ex(0,0,0,0,S_IDLE));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Two coins at once in IDLE and in ACCUM; coin during VEND.
    step_a(1,1,0,0, ex(0,0,1,0,S_IDLE));
    step_a(1,0,0,0, ex(0,0,0,1,S_ACCUM));
    step_a(1,1,0,0, ex(0,0,1,1,S_ACCUM));
    step_a(0,1,0,0, ex(1,0,0,0,S_VEND));
    step_a(1,0,0,0, ex(0,0,1,0,S_IDLE));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Cancel with a coin in ACCUM: refund, coin rejected.
    step_a(1,0,0,0, ex(0,0,0,1,S_ACCUM));
    step_a(0,1,0,1, ex(0,1,1,1,S_REFUND));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Maximum credit PRICE+4: Dime then Quarter -> 4 change nickels,
    // with a nickel inserted during CHANGE being rejected.
    step_a(0,1,0,0, ex(0,0,0,2,S_ACCUM));
    step_a(0,0,1,0, ex(1,0,0,4,S_VEND));
    step_a(0,0,0,0, ex(0,1,0,4,S_CHANGE));
    step_a(1,0,0,0, ex(0,1,1,3,S_CHANGE));
    step_a(0,0,0,1, ex(0,1,0,2,S_CHANGE));
    step_a(0,0,0,0, ex(0,1,0,1,S_CHANGE));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Quarter disabled on dut_b: rejected, no credit.
    step_b(0,0,1,0, ex(0,0,1,0,S_IDLE));
    step_b(0,0,0,0, ex(0,0,0,0,S_IDLE));
    step_b(0,1,0,0, ex(0,0,0,2,S_ACCUM));
    step_b(0,0,1,0, ex(0,0,1,2,S_ACCUM));
    step_b(1,0,0,0, ex(1,0,0,0,S_VEND));
    step_b(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Asynchronous reset during CHANGE with two nickels owed.
    step_a(0,0,1,0, ex(1,0,0,2,S_VEND));
    step_a(0,0,0,0, ex(0,1,0,2,S_CHANGE));
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", 0, {vend_a, change_a, rej_a, credit_a, state_a}, ex(0,0,0,0,S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));
    step_a(1,0,0,0, ex(0,0,0,1,S_ACCUM));
    step_a(0,0,0,1, ex(0,1,0,1,S_REFUND));
    step_a(0,0,0,0, ex(0,0,0,0,S_IDLE));

    // Let the monitors drain, bounded.
    waited = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    #1;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: got %0d entries left, want 0", q_a.size() + q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vending_moore_change.md
# vending_moore_change

Parametrised Moore vending controller, successor to the fixed 15-cent nickel/dime machine. It takes a configurable price, accepts nickels, dimes and optionally quarters, and tracks credit in a binary counter rather than one state per amount. It dispenses change one nickel per cycle and supports a cancel/refund request. It sits between the debounced coin-acceptor pulses and the dispenser/coin-return actuators.

## Interface
- PRICE, 3: item price in nickel units (3 = 15 cents); legal range 1..63.
- QUARTER_EN, 1: 1 = quarter input is accepted; 0 = any quarter is rejected.
- CREDIT_W (localparam): $clog2(PRICE+5); wide enough for the maximum credit of PRICE+4.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- Nickel  in  1  one-cycle coin pulse, 5 cents.
- Dime  in  1  one-cycle coin pulse, 10 cents.
- Quarter  in  1  one-cycle coin pulse, 25 cents.
- Cancel  in  1  refund request.
- Vend  out  1  dispense item; high for exactly one cycle.
- Change  out  1  eject one nickel; high for one cycle per nickel owed.
- Coin_reject  out  1  coin returned to the customer; one-cycle pulse.
- Credit  out  CREDIT_W  current credit in nickels.
- State_out  out  3  state encoding, for debug LEDs.

## Operation
- States: IDLE (credit 0), ACCUM (0 < credit < PRICE), VEND, CHANGE, REFUND.
- Coin decode:
  - Exactly one coin input high gives the value N=1, D=2, Q=5.
  - More than one coin high, or Quarter high with QUARTER_EN=0, makes the coin invalid.
- IDLE/ACCUM:
  - A valid coin sets credit += value.
  - If the new credit ≥ PRICE: go to VEND and set credit = new credit − PRICE.
  - Otherwise stay in ACCUM.
  - An invalid coin leaves credit unchanged and sets Coin_reject=1 next cycle.
- Cancel in ACCUM goes to REFUND. Cancel in IDLE is ignored.
- Cancel and a coin in the same cycle: Cancel wins and the coin is rejected.
- VEND:
  - Vend=1 for this cycle.
  - Next state is CHANGE if credit > 0, else IDLE.
- CHANGE/REFUND:
  - Change=1 each cycle and credit decrements by 1 at the cycle end.
  - When credit goes 1→0, the next state is IDLE.
  - Cancel is ignored in these states.
- Any coin arriving in VEND/CHANGE/REFUND is rejected (Coin_reject next cycle) and never credited.
- Credit never exceeds PRICE+4 and never underflows. No saturation logic is needed; an assertion checks the bound.

## Timing
- All state and credit registers update on posedge clk.
- Vend, Change and State_out are decoded solely from the state register (Moore). There is no combinational path from any input to any output.
- Coin_reject and Credit are registered.
- Coin-to-Vend latency: a coin sampled at edge k that completes the price gives Vend high from edge k to edge k+1.
- Change pulses: the K change nickels occupy the K cycles immediately after the Vend cycle.
- Refund: the first Change pulse appears in the cycle after the edge that sampled Cancel.
- Reset values: state IDLE, Credit 0, Vend 0, Change 0, Coin_reject 0, State_out 3'b000. Reset takes effect asynchronously, including mid-CHANGE, and any owed change is discarded.
- Reset release is synchronous to clk through the standard reset synchroniser, which sits outside this block.

## Structure
- Package vending_pkg holds:
  - the state enum, with IDLE=0, ACCUM=1, VEND=2, CHANGE=3, REFUND=4;
  - the coin value constants (NICKEL_V=1, DIME_V=2, QUARTER_V=5).
- Sub-module coin_decoder is combinational. It takes the coin inputs plus QUARTER_EN and produces valid, invalid and value[2:0].
- The top module contains the state register, credit counter, reject flag and output decode.

## Test plan
- PRICE=3: reset; Nickel, then Dime on the next cycle → Vend=1 for one cycle, no Change, Credit=0, back to IDLE.
- PRICE=3: Dime, Dime → Credit 2, then Vend with Credit=1 → one Change pulse on the next cycle → IDLE.
- PRICE=3, QUARTER_EN=1: Quarter from IDLE → Vend, then two consecutive Change pulses → Credit 0.
- QUARTER_EN=0: Quarter → Coin_reject pulse and Credit stays 0.
- Nickel followed by Cancel → REFUND with one Change pulse, then IDLE. Cancel in IDLE → no output activity.
- Nickel+Dime in the same cycle → Coin_reject and Credit unchanged. Nickel during VEND → Coin_reject.
- Reset asserted during CHANGE with 2 nickels owed → all outputs 0 immediately (before the next edge) and state IDLE.
